// File: rtl/io_request_arbiter.sv
// io_request_arbiter: round-robin admission of NUM_REQ requesters onto one downstream IO
// channel, with an in-order tag FIFO steering responses back. Option: IOARB_FIXED_PRIORITY_EN.
module io_request_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned TAG_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   async_rst,
    input  logic                   clk_en,
    input  logic [NUM_REQ-1:0]     ReqIn,
    output logic [NUM_REQ-1:0]     ReqAck,
    input  logic [NUM_REQ-1:0]     ReqRespRequested,
    input  logic [4*NUM_REQ-1:0]   ReqDestReg,
    input  logic [32*NUM_REQ-1:0]  ReqData,
    output logic                   DownReq,
    input  logic                   DownAck,
    output logic                   DownRespRequested,
    output logic [3:0]             DownDestReg,
    output logic [31:0]            DownData,
    input  logic                   RespReqIn,
    output logic                   RespAckOut,
    input  logic [3:0]             RespDestReg,
    input  logic [31:0]            RespData,
    output logic [NUM_REQ-1:0]     RespReqOut,
    input  logic [NUM_REQ-1:0]     RespAckIn,
    output logic [3:0]             RespDestRegOut,
    output logic [31:0]            RespDataOut,
    output logic                   OrphanFlag
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam logic [PW:0]   NREQ_W   = (PW+1)'(NUM_REQ);
    localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);
    localparam logic [TW:0]   DEPTH_W  = (TW+1)'(TAG_DEPTH);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    state_t             state;
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      owner;
    logic [PW-1:0]      win;
    logic [PW-1:0]      win_next;
    logic               win_valid;
    logic [PW:0]        rr_sum;
    logic [PW-1:0]      rr_idx;
    logic [NUM_REQ-1:0] eligible;

    logic               sel_resp;
    logic [3:0]         sel_dest;
    logic [31:0]        sel_data;

    logic [PW-1:0]      tag_mem [TAG_DEPTH];
    logic [TW-1:0]      wr_ptr;
    logic [TW-1:0]      rd_ptr;
    logic [TW:0]        count;
    logic               fifo_full;
    logic               fifo_empty;
    logic [PW-1:0]      head;

    logic               active;
    logic               grant;
    logic               push;
    logic               pop;
    logic               orphan_hit;

    // Combinational handshakes are suppressed while frozen or held in reset.
    assign active     = clk_en & async_rst;
    assign fifo_full  = (count == DEPTH_W);
    assign fifo_empty = (count == '0);
    assign head       = tag_mem[rd_ptr];

    assign eligible = ReqIn & ~(ReqRespRequested & {NUM_REQ{fifo_full}});

    always_comb begin
        win_valid = 1'b0;
        win       = '0;
        rr_sum    = '0;
        rr_idx    = '0;
`ifdef IOARB_FIXED_PRIORITY_EN
        if (eligible[0]) begin
            win_valid = 1'b1;
        end
`endif
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            rr_sum = {1'b0, rr_ptr} + (PW+1)'(k);
            if (rr_sum >= NREQ_W) begin
                rr_sum = rr_sum - NREQ_W;
            end
            rr_idx = rr_sum[PW-1:0];
            if (!win_valid && eligible[rr_idx]) begin
                win_valid = 1'b1;
                win       = rr_idx;
            end
        end
    end

    assign win_next = (win == LAST_IDX) ? '0 : win + 1'b1;

    always_comb begin
        sel_resp = 1'b0;
        sel_dest = '0;
        sel_data = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (PW'(k) == win) begin
                sel_resp = ReqRespRequested[k];
                sel_dest = ReqDestReg[4*k +: 4];
                sel_data = ReqData[32*k +: 32];
            end
        end
    end

    assign grant = active & (state == IDLE) & win_valid;

    always_comb begin
        ReqAck = '0;
        if (grant) begin
            ReqAck[win] = 1'b1;
        end
    end

    assign push = active & (state == PRESENT) & DownAck & DownRespRequested;

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            owner             <= '0;
            DownReq           <= 1'b0;
            DownRespRequested <= 1'b0;
            DownDestReg       <= '0;
            DownData          <= '0;
        end else if (clk_en) begin
            unique case (state)
                IDLE: begin
                    if (win_valid) begin
                        owner             <= win;
                        DownRespRequested <= sel_resp;
                        DownDestReg       <= sel_dest;
                        DownData          <= sel_data;
                        DownReq           <= 1'b1;
                        state             <= PRESENT;
`ifdef IOARB_FIXED_PRIORITY_EN
                        if (win != '0) begin
                            rr_ptr <= win_next;
                        end
`else
                        rr_ptr <= win_next;
`endif
                    end
                end
                PRESENT: begin
                    if (DownAck) begin
                        DownReq <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Responses come back in issue order, so the FIFO head names the requester.
    always_comb begin
        RespReqOut = '0;
        if (active && !fifo_empty) begin
            RespReqOut[head] = RespReqIn;
        end
    end

    assign RespAckOut     = active & (fifo_empty ? RespReqIn : RespAckIn[head]);
    assign pop            = active & ~fifo_empty & RespReqIn & RespAckIn[head];
    assign orphan_hit     = active & fifo_empty & RespReqIn;
    assign RespDestRegOut = async_rst ? RespDestReg : '0;
    assign RespDataOut    = async_rst ? RespData : '0;

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            OrphanFlag <= 1'b0;
            for (int unsigned k = 0; k < TAG_DEPTH; k++) begin
                tag_mem[k] <= '0;
            end
        end else if (clk_en) begin
            if (push) begin
                tag_mem[wr_ptr] <= owner;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (orphan_hit) begin
                OrphanFlag <= 1'b1;
            end
        end
    end

    a_ack_onehot : assert property (@(posedge clk) disable iff (!async_rst) $onehot0(ReqAck));
    a_no_overflow : assert property (@(posedge clk) disable iff (!async_rst)
                                     !(push && !pop && fifo_full));

endmodule

// File: tb/tb_io_request_arbiter.sv
// Bench for io_request_arbiter: directed table and sequences plus random traffic checked
// against a queue-based reference model of arbitration and response routing.
module tb_io_request_arbiter;

    localparam int N  = 4;
    localparam int TD = 4;

    logic            clk = 1'b0;
    logic            async_rst;
    logic            clk_en;
    logic [N-1:0]    ReqIn;
    logic [N-1:0]    ReqAck;
    logic [N-1:0]    ReqRespRequested;
    logic [4*N-1:0]  ReqDestReg;
    logic [32*N-1:0] ReqData;
    logic            DownReq;
    logic            DownAck;
    logic            DownRespRequested;
    logic [3:0]      DownDestReg;
    logic [31:0]     DownData;
    logic            RespReqIn;
    logic            RespAckOut;
    logic [3:0]      RespDestReg;
    logic [31:0]     RespData;
    logic [N-1:0]    RespReqOut;
    logic [N-1:0]    RespAckIn;
    logic [3:0]      RespDestRegOut;
    logic [31:0]     RespDataOut;
    logic            OrphanFlag;

    int n_checks = 0;
    int n_fail   = 0;
    logic [N-1:0] acked;

    // Reference model state
    int          m_ptr;
    bit          m_busy;
    int          m_owner;
    bit          m_resp;
    logic [3:0]  m_dest;
    logic [31:0] m_data;
    int          m_tags[$];
    bit          m_orphan;
    int          m_win;

    typedef struct {
        logic [N-1:0] req_in;
        logic         down_ack;
        logic [N-1:0] exp_ack;
        logic         exp_dreq;
        logic [31:0]  exp_data;
    } vec_t;

    vec_t tbl [18];
    int   gseq [9];
    int   ord [4];

    io_request_arbiter #(.NUM_REQ(N), .TAG_DEPTH(TD)) dut (
        .clk(clk), .async_rst(async_rst), .clk_en(clk_en),
        .ReqIn(ReqIn), .ReqAck(ReqAck), .ReqRespRequested(ReqRespRequested),
        .ReqDestReg(ReqDestReg), .ReqData(ReqData),
        .DownReq(DownReq), .DownAck(DownAck), .DownRespRequested(DownRespRequested),
        .DownDestReg(DownDestReg), .DownData(DownData),
        .RespReqIn(RespReqIn), .RespAckOut(RespAckOut), .RespDestReg(RespDestReg),
        .RespData(RespData), .RespReqOut(RespReqOut), .RespAckIn(RespAckIn),
        .RespDestRegOut(RespDestRegOut), .RespDataOut(RespDataOut), .OrphanFlag(OrphanFlag)
    );

    always #10 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int w);
        logic [N-1:0] v;
        v = '0;
        if (w >= 0) v[w] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_ptr    = 0;
        m_busy   = 0;
        m_owner  = 0;
        m_resp   = 0;
        m_dest   = '0;
        m_data   = '0;
        m_orphan = 0;
        m_tags.delete();
    endtask

    function automatic int model_winner();
        bit el [N];
        int w;
        w = -1;
        if (!m_busy && clk_en) begin
            for (int i = 0; i < N; i++)
                el[i] = ReqIn[i] && !(ReqRespRequested[i] && m_tags.size() == TD);
`ifdef IOARB_FIXED_PRIORITY_EN
            if (el[0]) w = 0;
`endif
            for (int k = 0; k < N; k++)
                if (w < 0 && el[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        end
        return w;
    endfunction

    task automatic model_check(input int w);
        logic [N-1:0] e_rro;
        logic         e_rao;
        e_rro = '0;
        e_rao = 1'b0;
        if (clk_en) begin
            if (m_tags.size() == 0) begin
                e_rao = RespReqIn;
            end else begin
                e_rro[m_tags[0]] = RespReqIn;
                e_rao = RespAckIn[m_tags[0]];
            end
        end
        check("m_ReqAck", 64'(ReqAck), 64'(onehot(w)));
        check("m_DownReq", 64'(DownReq), 64'(m_busy));
        check("m_DownRespRequested", 64'(DownRespRequested), 64'(m_resp));
        check("m_DownDestReg", 64'(DownDestReg), 64'(m_dest));
        check("m_DownData", 64'(DownData), 64'(m_data));
        check("m_RespReqOut", 64'(RespReqOut), 64'(e_rro));
        check("m_RespAckOut", 64'(RespAckOut), 64'(e_rao));
        check("m_RespDestRegOut", 64'(RespDestRegOut), 64'(RespDestReg));
        check("m_RespDataOut", 64'(RespDataOut), 64'(RespData));
        check("m_OrphanFlag", 64'(OrphanFlag), 64'(m_orphan));
    endtask

    task automatic model_update(input int w);
        if (clk_en) begin
            if (RespReqIn) begin
                if (m_tags.size() == 0) m_orphan = 1;
                else if (RespAckIn[m_tags[0]]) void'(m_tags.pop_front());
            end
            if (m_busy) begin
                if (DownAck) begin
                    if (m_resp) m_tags.push_back(m_owner);
                    m_busy = 0;
                end
            end else if (w >= 0) begin
                m_busy  = 1;
                m_owner = w;
                m_resp  = ReqRespRequested[w];
                m_dest  = ReqDestReg[4*w +: 4];
                m_data  = ReqData[32*w +: 32];
`ifdef IOARB_FIXED_PRIORITY_EN
                if (w != 0) m_ptr = (w + 1) % N;
`else
                m_ptr = (w + 1) % N;
`endif
            end
        end
    endtask

    // pre: settle after the falling edge; post: model compare, model step, next falling edge
    task automatic pre();
        #2;
    endtask

    task automatic post();
        m_win = model_winner();
        model_check(m_win);
        acked = ReqAck;
        model_update(m_win);
        @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        check({name, "_ReqAck"}, 64'(ReqAck), 64'd0);
        check({name, "_DownReq"}, 64'(DownReq), 64'd0);
        check({name, "_DownRespRequested"}, 64'(DownRespRequested), 64'd0);
        check({name, "_DownDestReg"}, 64'(DownDestReg), 64'd0);
        check({name, "_DownData"}, 64'(DownData), 64'd0);
        check({name, "_RespReqOut"}, 64'(RespReqOut), 64'd0);
        check({name, "_RespAckOut"}, 64'(RespAckOut), 64'd0);
        check({name, "_RespDestRegOut"}, 64'(RespDestRegOut), 64'd0);
        check({name, "_RespDataOut"}, 64'(RespDataOut), 64'd0);
        check({name, "_OrphanFlag"}, 64'(OrphanFlag), 64'd0);
    endtask

    task automatic set_req(input int i, input bit resp, input logic [3:0] dest,
                           input logic [31:0] data);
        ReqRespRequested[i]  = resp;
        ReqDestReg[4*i +: 4] = dest;
        ReqData[32*i +: 32]  = data;
    endtask

    task automatic send_one(input int i, input bit resp, input logic [3:0] dest,
                            input logic [31:0] data);
        int budget;
        bit got;
        budget = 20;
        got = 0;
        set_req(i, resp, dest, data);
        ReqIn = '0;
        ReqIn[i] = 1'b1;
        DownAck = 1'b1;
        while (!got && budget > 0) begin
            pre();
            got = ReqAck[i];
            post();
            budget--;
        end
        check("send_granted", 64'(got), 64'd1);
        ReqIn[i] = 1'b0;
        pre();
        check("send_DownReq", 64'(DownReq), 64'd1);
        check("send_DownDestReg", 64'(DownDestReg), 64'(dest));
        check("send_DownData", 64'(DownData), 64'(data));
        post();
    endtask

    initial begin
        async_rst = 1'b0;
        clk_en = 1'b1;
        ReqIn = '0;
        ReqRespRequested = '0;
        ReqDestReg = '0;
        ReqData = '0;
        DownAck = 1'b0;
        RespReqIn = 1'b0;
        RespDestReg = '0;
        RespData = '0;
        RespAckIn = '0;
        acked = '0;
        model_reset();
        #5;
        check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        async_rst = 1'b1;

        // Round-robin sweep with every requester asserted, then requester 0 dropped
`ifdef IOARB_FIXED_PRIORITY_EN
        gseq = '{0, 0, 0, 0, 0, 1, 2, 3, 1};
`else
        gseq = '{0, 1, 2, 3, 0, 1, 2, 3, 1};
`endif
        for (int r = 0; r < 18; r++) begin
            tbl[r].req_in   = (r < 10) ? 4'b1111 : 4'b1110;
            tbl[r].down_ack = 1'b1;
            tbl[r].exp_ack  = (r % 2 == 0) ? onehot(gseq[r/2]) : '0;
            tbl[r].exp_dreq = (r % 2 == 1);
            tbl[r].exp_data = (r == 0) ? 32'h0 : 32'hA000_0000 + 32'(gseq[(r-1)/2]);
        end
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 4'(i), 32'hA000_0000 + 32'(i));
        for (int r = 0; r < 18; r++) begin
            ReqIn = tbl[r].req_in;
            DownAck = tbl[r].down_ack;
            pre();
            check("tbl_ReqAck", 64'(ReqAck), 64'(tbl[r].exp_ack));
            check("tbl_DownReq", 64'(DownReq), 64'(tbl[r].exp_dreq));
            check("tbl_DownData", 64'(DownData), 64'(tbl[r].exp_data));
            post();
        end
        ReqIn = '0;

        // Single response-requested transaction routed back to requester 2
        set_req(2, 1'b1, 4'd5, 32'hBEEF_0002);
        ReqIn = 4'b0100;
        pre();
        check("t2_ReqAck", 64'(ReqAck), 64'b0100);
        post();
        ReqIn = '0;
        pre();
        check("t2_DownRespRequested", 64'(DownRespRequested), 64'd1);
        check("t2_DownDestReg", 64'(DownDestReg), 64'd5);
        post();
        RespReqIn = 1'b1;
        RespData = 32'h1234_5678;
        RespDestReg = 4'd5;
        RespAckIn = 4'b1111;
        pre();
        check("t2_RespReqOut", 64'(RespReqOut), 64'b0100);
        check("t2_RespDataOut", 64'(RespDataOut), 64'h1234_5678);
        check("t2_RespDestRegOut", 64'(RespDestRegOut), 64'd5);
        check("t2_RespAckOut", 64'(RespAckOut), 64'd1);
        post();

        // FIFO now empty: next response is an orphan
        RespAckIn = '0;
        pre();
        check("orphan_RespReqOut", 64'(RespReqOut), 64'd0);
        check("orphan_RespAckOut", 64'(RespAckOut), 64'd1);
        post();
        RespReqIn = 1'b0;
        for (int c = 0; c < 3; c++) begin
            pre();
            check("orphan_sticky", 64'(OrphanFlag), 64'd1);
            post();
        end

        // Fill the tag FIFO, confirm back-pressure on response-requested traffic only
        ord = '{1, 3, 0, 2};
        for (int k = 0; k < 4; k++) send_one(ord[k], 1'b1, 4'(k), 32'hC0DE_0000 + 32'(k));
        set_req(1, 1'b1, 4'd9, 32'hDEAD_0001);
        ReqIn = 4'b0010;
        for (int c = 0; c < 6; c++) begin
            pre();
            check("full_block_ReqAck", 64'(ReqAck), 64'd0);
            post();
        end
        set_req(3, 1'b0, 4'd7, 32'hF00D_0003);
        ReqIn = 4'b1010;
        pre();
        check("full_plain_ReqAck", 64'(ReqAck), 64'b1000);
        post();
        ReqIn = 4'b0010;
        pre();
        check("full_plain_DownData", 64'(DownData), 64'hF00D_0003);
        post();
        ReqIn = '0;
        RespReqIn = 1'b1;
        RespAckIn = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            pre();
            check("route_RespReqOut", 64'(RespReqOut), 64'(onehot(ord[k])));
            check("route_RespAckOut", 64'(RespAckOut), 64'd1);
            post();
        end
        RespReqIn = 1'b0;

        // Downstream stall held in PRESENT
        set_req(0, 1'b0, 4'd3, 32'h5555_AAAA);
        set_req(2, 1'b0, 4'd4, 32'h2222_0000);
        ReqIn = 4'b0001;
        DownAck = 1'b0;
        pre();
        check("stall_ReqAck", 64'(ReqAck), 64'b0001);
        post();
        ReqIn = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            pre();
            check("stall_DownReq", 64'(DownReq), 64'd1);
            check("stall_DownData", 64'(DownData), 64'h5555_AAAA);
            check("stall_ReqAck_quiet", 64'(ReqAck), 64'd0);
            post();
        end
        DownAck = 1'b1;
        pre();
        check("stall_release_DownReq", 64'(DownReq), 64'd1);
        post();
        pre();
        check("stall_idle_DownReq", 64'(DownReq), 64'd0);
        check("stall_idle_ReqAck", 64'(ReqAck), 64'b0100);
        post();
        ReqIn = '0;
        pre();
        post();

        // Asynchronous reset in the middle of a presented transaction
        set_req(1, 1'b1, 4'd6, 32'h6666_0001);
        ReqIn = 4'b0010;
        DownAck = 1'b0;
        pre();
        check("rst_setup_ReqAck", 64'(ReqAck), 64'b0010);
        post();
        ReqIn = 4'b1111;
        RespReqIn = 1'b1;
        RespAckIn = 4'b1111;
        pre();
        async_rst = 1'b0;
        #1;
        check_zero("rst_mid");
        model_reset();
        ReqIn = '0;
        RespReqIn = 1'b0;
        RespAckIn = '0;
        @(negedge clk);
        @(negedge clk);
        async_rst = 1'b1;
        pre();
        check("rst_after_DownReq", 64'(DownReq), 64'd0);
        check("rst_after_OrphanFlag", 64'(OrphanFlag), 64'd0);
        post();

        // Random traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            clk_en      = ($urandom_range(0, 9) != 0);
            DownAck     = ($urandom_range(0, 3) != 0);
            RespReqIn   = ($urandom_range(0, 3) == 0);
            RespAckIn   = N'($urandom);
            RespDestReg = 4'($urandom);
            RespData    = $urandom;
            for (int i = 0; i < N; i++) begin
                if (!ReqIn[i] || acked[i]) begin
                    ReqIn[i] = ($urandom_range(0, 2) != 0);
                    set_req(i, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
                end
            end
            pre();
            post();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
